// File: rtl/cond_unit.sv
// cond_unit: holds NZCV, evaluates the condition field and gates the decoder's commit strobes.
// Define COND_PERF_CNT_EN to add the exec_count/squash_count performance counters.
module cond_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic [3:0]  Flags
`ifdef COND_PERF_CNT_EN
    ,
    output logic [31:0] exec_count,
    output logic [31:0] squash_count
`endif
);
    logic [1:0] nz, cv;
    logic       n, z, c, v, go;

    assign Flags      = {nz, cv};
    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = !z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = !c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = !n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = !v;
            4'b1000: CondEx = c & !z;
            4'b1001: CondEx = !c | z;
            4'b1010: CondEx = n == v;
            4'b1011: CondEx = n != v;
            4'b1100: CondEx = !z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // reset_n gates the strobes so nothing commits while the core is held in reset
    assign go       = reset_n & en & CondEx;
    assign PCSrc    = go & PCS;
    assign RegWrite = go & RegW;
    assign MemWrite = go & MemW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz <= 2'b00;
            cv <= 2'b00;
        end else begin
            if (go & FlagW[1]) nz <= ALUFlags[3:2];
            if (go & FlagW[0]) cv <= ALUFlags[1:0];
        end
    end

`ifdef COND_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_count   <= 32'd0;
            squash_count <= 32'd0;
        end else if (en) begin
            if (CondEx) exec_count <= exec_count + 32'd1;
            else squash_count <= squash_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: table vectors, reset/self-reference sequences, full condition sweep and
// randomized checking against a flag/condition reference model.
module tb_cond_unit;
    logic       clk = 1'b0;
    logic       reset_n, en, PCS, RegW, MemW;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [31:0] exec_count, squash_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] mflags;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk(clk), .reset_n(reset_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags)
`ifdef COND_PERF_CNT_EN
        , .exec_count(exec_count), .squash_count(squash_count)
`endif
    );

    typedef struct {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs, regw, memw;
        logic [3:0] e_flags;
        logic       e_cx, e_pc, e_rw, e_mw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] a,
                         input logic [1:0] w, input logic p, input logic r, input logic m);
        en = e; Cond = c; ALUFlags = a; FlagW = w; PCS = p; RegW = r; MemW = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Conditions come in pass/fail pairs: even code tests a predicate, odd code its inverse.
    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'hE, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'hE, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'hE, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 4'h1, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 4'h1, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset held with an always-executing, all-strobes instruction presented
        reset_n = 1'b0;
        drive(1'b1, 4'hE, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
        #1;
        chk("reset_flags", {28'd0, Flags}, 32'h0);
        chk("reset_strobes", {29'd0, PCSrc, RegWrite, MemWrite}, 32'h0);
        chk("reset_al_condex", {31'd0, CondEx}, 32'h1);
        Cond = 4'h0;
        #1;
        chk("reset_eq_condex", {31'd0, CondEx}, 32'h0);
        Cond = 4'hE;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("release_strobes", {29'd0, PCSrc, RegWrite, MemWrite}, 32'h7);
        drive(1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();

        // Directed vectors: compare/branch, partial update, squash, stall, self-reference
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].cond, tbl[i].alu, tbl[i].fw, tbl[i].pcs, tbl[i].regw, tbl[i].memw);
            @(negedge clk);
            chk($sformatf("tbl%0d_flags", i), {28'd0, Flags}, {28'd0, tbl[i].e_flags});
            chk($sformatf("tbl%0d_condex", i), {31'd0, CondEx}, {31'd0, tbl[i].e_cx});
            chk($sformatf("tbl%0d_strobes", i), {29'd0, PCSrc, RegWrite, MemWrite},
                {29'd0, tbl[i].e_pc, tbl[i].e_rw, tbl[i].e_mw});
            tick();
        end

        // Every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("sweep_load%0d", f), {28'd0, Flags}, 32'(f));
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 4'(c), 4'($urandom), 2'b00, 1'b0, 1'b1, 1'b0);
                @(negedge clk);
                chk($sformatf("sweep_c%0h_f%0h", c, f), {31'd0, RegWrite},
                    {31'd0, passes(4'(c), 4'(f))});
                tick();
            end
        end
        mflags = 4'hF;

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            logic       cx;
            logic [3:0] nxt;
            drive(($urandom % 8) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            cx = passes(Cond, mflags);
            @(negedge clk);
            chk($sformatf("rnd%0d_flags", k), {28'd0, Flags}, {28'd0, mflags});
            chk($sformatf("rnd%0d_condex", k), {31'd0, CondEx}, {31'd0, cx});
            chk($sformatf("rnd%0d_strobes", k), {29'd0, PCSrc, RegWrite, MemWrite},
                {29'd0, en && cx && PCS, en && cx && RegW, en && cx && MemW});
            nxt = mflags;
            if (en && cx && FlagW[1]) nxt[3:2] = ALUFlags[3:2];
            if (en && cx && FlagW[0]) nxt[1:0] = ALUFlags[1:0];
            tick();
            mflags = nxt;
        end

        // Asynchronous reset mid-cycle clears flags at once; release needs no dead cycle
        drive(1'b1, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("preset_flags", {28'd0, Flags}, 32'hF);
        drive(1'b1, 4'hE, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_flags", {28'd0, Flags}, 32'h0);
        chk("async_reset_strobes", {29'd0, PCSrc, RegWrite, MemWrite}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_release_strobes", {29'd0, PCSrc, RegWrite, MemWrite}, 32'h7);
        tick();
        chk("post_release_update", {28'd0, Flags}, 32'hA);

`ifdef COND_PERF_CNT_EN
        drive(1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin drive(1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1'b1, 4'hF, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0); tick(); end
        chk("exec_count", exec_count, 32'd3);
        chk("squash_count", squash_count, 32'd2);
        chk("stall_flags", {28'd0, Flags}, 32'h0);
        force dut.exec_count = 32'hFFFF_FFFF;
        #1 release dut.exec_count;
        #1;
        chk("exec_preload", exec_count, 32'hFFFF_FFFF);
        drive(1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("exec_wrap", exec_count, 32'd0);
        chk("squash_hold", squash_count, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the single-cycle 32-bit ARM-subset core. It is the consumer of the instruction decoder's control outputs (FlagW, PCS, RegW, MemW). It holds the architectural NZCV flags, evaluates the instruction's 4-bit condition field against them, and turns the decoder's raw controls into the committed PCSrc, RegWrite and MemWrite strobes. Flags update on the clock edge; the gating path is combinational so the datapath commits in the same cycle.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- en  in  1  instruction valid/advance; 0 = bubble or stall, nothing commits
- Cond  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  decoder flag-write request; [1] = N,Z, [0] = C,V
- PCS  in  1  decoder PC-source request
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- PCSrc  out  1  committed PC write (branch or write to R15)
- RegWrite  out  1  committed register-file write
- MemWrite  out  1  committed data-memory write
- CondEx  out  1  condition passed against the stored flags
- Flags  out  4  stored {N,Z,C,V}

## Operation
- State: two flag registers.
  - NZ is 2 bits, holding N and Z.
  - CV is 2 bits, holding C and V.
- CondEx is evaluated against the stored Flags, never against ALUFlags:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C & !Z
  - LS 1001: !C | Z
  - GE 1010: N == V
  - LT 1011: N != V
  - GT 1100: !Z & (N == V)
  - LE 1101: Z | (N != V)
  - AL 1110: 1
  - 1111: reserved, CondEx = 0 (the instruction is squashed)
- Committed strobes (each is 0 while reset_n is low):
  - PCSrc = en & CondEx & PCS
  - RegWrite = en & CondEx & RegW
  - MemWrite = en & CondEx & MemW
- Flag update on the rising edge:
  - NZ <= ALUFlags[3:2] when en & CondEx & FlagW[1].
  - CV <= ALUFlags[1:0] when en & CondEx & FlagW[0].
  - The two halves update independently; otherwise each holds its value.
- A squashed instruction (CondEx = 0) changes no flags and asserts no strobe.
- FlagW = 2'b10 (logical op with S set) updates N,Z only; C,V are preserved.

## Timing
- Reset: when reset_n falls, Flags = 4'b0000 immediately.
  - PCSrc, RegWrite and MemWrite are forced to 0 for as long as reset_n is low.
  - CondEx reflects the cleared flags (AL = 1, EQ = 0).
- Reset released mid-instruction: the first rising edge with reset_n high may update flags normally. There is no extra dead cycle.
- Gating latency is 0 cycles; it is a combinational path from Cond, en and the decoder inputs to the strobes.
- Flag latency is 1 cycle. A flag-setting instruction in cycle t is visible to CondEx in cycle t+1, so back-to-back CMP then BEQ works with no bubble.
- Self-reference: an instruction that sets flags and is itself conditional uses the pre-update flags to decide whether it executes.
- en = 0 acts as a full stall: flags hold and all strobes are 0, whatever the inputs are.

## Configuration
- COND_PERF_CNT_EN defined:
  - Adds output exec_count (32 bits). It increments on each rising edge with en & CondEx.
  - Adds output squash_count (32 bits). It increments on each rising edge with en & !CondEx.
  - Both counters reset asynchronously to 0 and wrap from 0xFFFFFFFF to 0.
  - en = 0 cycles count toward neither counter.
- COND_PERF_CNT_EN undefined: the counters and ports are absent, and the logic listed above is otherwise identical.

## Test plan
- Reset: drive reset_n = 0 with en = 1, Cond = 1110, PCS = RegW = MemW = 1.
  - Required: Flags = 0000 and all strobes 0. After release, all strobes are 1.
- Compare then branch: cycle 1 has Cond = 1110, FlagW = 11, ALUFlags = 0100. Cycle 2 has Cond = 0000, PCS = 1.
  - Required: Flags = 0100 and PCSrc = 1 in cycle 2. With ALUFlags = 0000 in cycle 1, PCSrc = 0 in cycle 2.
- Partial update: Flags = 0011, then FlagW = 10 with ALUFlags = 1000 and Cond = 1110.
  - Required: Flags = 1011 next cycle.
- Squash: Flags = 0000, Cond = 0000, RegW = 1, MemW = 1, FlagW = 11, ALUFlags = 1111.
  - Required: RegWrite = 0, MemWrite = 0, Flags remain 0000.
- Signed conditions: sweep all 16 Cond values against each of the 16 Flags values with RegW = 1.
  - Required: RegWrite matches the condition list exactly. Cond = 1111 always gives 0.
- Stall and counters (with COND_PERF_CNT_EN): run 3 executed, 2 squashed and 4 en = 0 cycles.
  - Required: exec_count = 3, squash_count = 2, flags unchanged across the stall cycles.
  - Preload exec_count to 0xFFFFFFFF; one more executed cycle gives 0.
